// File: rtl/fp_normalize_pack.sv
// fp_normalize_pack
//
// Back end of the FPU add path. Takes the raw (unnormalized) mantissa
// sum/difference from the adder together with the aligned exponent, sign and
// special-case tag. It normalizes, rounds, detects overflow/underflow and
// packs an IEEE-754 single-precision word.
//
// Three-stage pipeline:
//   S1  classify the beat (NaN / Inf / zero / ordinary) and count leading zeros
//   S2  normalize: carry right-shift or leading-zero left-shift, underflow check
//   S3  round to nearest even (optional), overflow check, pack the word
//
// A single global stall (result held and not accepted) freezes every stage.
//
// Build option:
//   FP_NORM_ROUND_EN  defined   -> round-to-nearest-even on G/R/S
//                     undefined -> truncation, G/R/S ignored, no round adder
//
// Parameters:
//   QNAN        word emitted for any NaN result
//   FLUSH_SIGN  sign bit used for exact-zero results
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   sum_vld   in   input beat valid
//   sum_rdy   out  block can accept a beat
//   sum_sign  in   result sign from adder
//   sum_exp   in   [7:0]  aligned (larger) biased exponent
//   sum_mant  in   [24:0] raw mantissa; bit24 = carry, bit23 = hidden position
//   sum_grs   in   [2:0]  guard/round/sticky from the alignment shift
//   in_state  in   [1:0]  00 OK, 01 NAN, 10 INF, 11 NUL
//   result    out  [31:0] packed IEEE-754 single
//   state     out  [1:0]  00 OK, 01 NAN, 10 INF, 11 NUL
//   res_vld   out  result valid
//   res_rdy   in   downstream accepts result

module fp_normalize_pack #(
    parameter logic [31:0] QNAN       = 32'h7FC0_0000,
    parameter logic        FLUSH_SIGN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sum_vld,
    output logic        sum_rdy,
    input  logic        sum_sign,
    input  logic [7:0]  sum_exp,
    input  logic [24:0] sum_mant,
    input  logic [2:0]  sum_grs,
    input  logic [1:0]  in_state,
    output logic [31:0] result,
    output logic [1:0]  state,
    output logic        res_vld,
    input  logic        res_rdy
);

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_NAN = 2'b01;
    localparam logic [1:0] ST_INF = 2'b10;
    localparam logic [1:0] ST_NUL = 2'b11;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic stall;
    logic accept;

    assign stall   = res_vld & ~res_rdy;
    assign sum_rdy = ~stall;
    assign accept  = sum_vld & sum_rdy;

    // ------------------------------------------------------------------
    // S1: classify and leading-zero count
    // ------------------------------------------------------------------
    logic [27:0] in_ext;
    logic [1:0]  in_tag;
    logic        in_sign;
    logic [4:0]  in_lz;

    assign in_ext = {sum_mant, sum_grs};

    always_comb begin
        in_tag  = ST_OK;
        in_sign = sum_sign;
        if (in_state == ST_NAN) begin
            in_tag = ST_NAN;
        end else if (in_state == ST_INF) begin
            in_tag = ST_INF;
        end else if (in_state == ST_NUL || in_ext == 28'd0) begin
            // Exact zero: the sign is fixed here so S3 packs it uniformly
            in_tag  = ST_NUL;
            in_sign = FLUSH_SIGN;
        end
    end

    // Ascending scan: the highest set bit is written last and wins.
    // An all-zero field yields 27, which only happens on carry or zero beats
    // where the count is not used.
    always_comb begin
        in_lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (in_ext[i]) begin
                in_lz = 5'(26 - i);
            end
        end
    end

    logic        s1_vld;
    logic [1:0]  s1_tag;
    logic        s1_sign;
    logic [7:0]  s1_exp;
    logic [27:0] s1_ext;
    logic [4:0]  s1_lz;
    logic        s1_carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld   <= 1'b0;
            s1_tag   <= ST_OK;
            s1_sign  <= 1'b0;
            s1_exp   <= 8'd0;
            s1_ext   <= 28'd0;
            s1_lz    <= 5'd0;
            s1_carry <= 1'b0;
        end else if (!stall) begin
            s1_vld <= accept;
            if (accept) begin
                s1_tag   <= in_tag;
                s1_sign  <= in_sign;
                s1_exp   <= sum_exp;
                s1_ext   <= in_ext;
                s1_lz    <= in_lz;
                s1_carry <= in_ext[27];
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: normalize shift and underflow detection
    // ------------------------------------------------------------------
    logic [27:0] norm_ext;
    logic [9:0]  norm_e;
    logic        norm_uf;
    logic [1:0]  norm_tag;

    always_comb begin
        norm_ext = s1_ext;
        norm_e   = {2'b00, s1_exp};
        norm_uf  = 1'b0;
        if (s1_carry) begin
            // Bit shifted out is folded into sticky so rounding still sees it
            norm_ext = {1'b0, s1_ext[27:2], s1_ext[1] | s1_ext[0]};
            norm_e   = {2'b00, s1_exp} + 10'd1;
        end else begin
            norm_ext = s1_ext << s1_lz;
            norm_e   = {2'b00, s1_exp} - {5'd0, s1_lz};
            norm_uf  = ($signed(norm_e) < 10'sd1);
        end
        norm_tag = s1_tag;
        if (s1_tag == ST_OK && norm_uf) begin
            norm_tag = ST_NUL;
        end
    end

    logic        s2_vld;
    logic [1:0]  s2_tag;
    logic        s2_sign;
    logic [9:0]  s2_e;
    logic [27:0] s2_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld  <= 1'b0;
            s2_tag  <= ST_OK;
            s2_sign <= 1'b0;
            s2_e    <= 10'd0;
            s2_ext  <= 28'd0;
        end else if (!stall) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_tag  <= norm_tag;
                s2_sign <= s1_sign;
                s2_e    <= norm_e;
                s2_ext  <= norm_ext;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: round, overflow, pack
    // ------------------------------------------------------------------
    logic [23:0] rnd_m;
    logic [9:0]  rnd_e;
    logic        rnd_ovf;
    logic        unused_bits;

`ifdef FP_NORM_ROUND_EN
    logic        rnd_inc;
    logic [24:0] rnd_sum;

    always_comb begin
        rnd_inc = s2_ext[2] & (s2_ext[1] | s2_ext[0] | s2_ext[3]);
        rnd_sum = {1'b0, s2_ext[26:3]} + {24'd0, rnd_inc};
        rnd_m   = rnd_sum[23:0];
        rnd_e   = s2_e;
        if (rnd_sum[24]) begin
            // Mantissa rolled over to 2^24: renormalize to 1.0 x 2^(e+1)
            rnd_m = 24'h80_0000;
            rnd_e = s2_e + 10'd1;
        end
    end

    assign unused_bits = s2_ext[27] ^ rnd_m[23];
`else
    assign rnd_m       = s2_ext[26:3];
    assign rnd_e       = s2_e;
    assign unused_bits = ^{s2_ext[27], s2_ext[2:0], rnd_m[23]};
`endif

    assign rnd_ovf = ($signed(rnd_e) >= 10'sd255);

    logic [31:0] pack_res;
    logic [1:0]  pack_st;

    always_comb begin
        pack_res = 32'd0;
        pack_st  = ST_OK;
        case (s2_tag)
            ST_NAN: begin
                pack_res = QNAN;
                pack_st  = ST_NAN;
            end
            ST_INF: begin
                pack_res = {s2_sign, 8'hFF, 23'd0};
                pack_st  = ST_INF;
            end
            ST_NUL: begin
                pack_res = {s2_sign, 31'd0};
                pack_st  = ST_NUL;
            end
            default: begin
                if (rnd_ovf) begin
                    pack_res = {s2_sign, 8'hFF, 23'd0};
                    pack_st  = ST_INF;
                end else begin
                    pack_res = {s2_sign, rnd_e[7:0], rnd_m[22:0]};
                    pack_st  = ST_OK;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_vld <= 1'b0;
            result  <= 32'd0;
            state   <= ST_OK;
        end else if (!stall) begin
            res_vld <= s2_vld;
            if (s2_vld) begin
                result <= pack_res;
                state  <= pack_st;
            end
        end
    end

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Directed self-checking bench for fp_normalize_pack.
// Expected words are hand-computed IEEE-754 encodings; the rounding vector
// picks its expectation from the FP_NORM_ROUND_EN build option.

module tb_fp_normalize_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        sum_vld;
    logic        sum_rdy;
    logic        sum_sign;
    logic [7:0]  sum_exp;
    logic [24:0] sum_mant;
    logic [2:0]  sum_grs;
    logic [1:0]  in_state;
    logic [31:0] result;
    logic [1:0]  state;
    logic        res_vld;
    logic        res_rdy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fp_normalize_pack dut (
        .clk      (clk),
        .rst      (rst),
        .sum_vld  (sum_vld),
        .sum_rdy  (sum_rdy),
        .sum_sign (sum_sign),
        .sum_exp  (sum_exp),
        .sum_mant (sum_mant),
        .sum_grs  (sum_grs),
        .in_state (in_state),
        .result   (result),
        .state    (state),
        .res_vld  (res_vld),
        .res_rdy  (res_rdy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic sgn, input logic [7:0] ex, input logic [24:0] mt,
                         input logic [2:0] g, input logic [1:0] st);
        sum_sign = sgn;
        sum_exp  = ex;
        sum_mant = mt;
        sum_grs  = g;
        in_state = st;
    endtask

    // One isolated beat: accepted at the first posedge, res_vld must appear
    // exactly after the third posedge counted from that accept edge.
    task automatic run_beat(input string tag, input logic sgn, input logic [7:0] ex,
                            input logic [24:0] mt, input logic [2:0] g, input logic [1:0] st,
                            input logic [31:0] er, input logic [1:0] es);
        @(negedge clk);
        drive(sgn, ex, mt, g, st);
        sum_vld = 1'b1;
        chk($sformatf("%s_rdy", tag), 32'(sum_rdy), 32'd1);
        @(negedge clk);
        sum_vld = 1'b0;
        chk($sformatf("%s_lat1", tag), 32'(res_vld), 32'd0);
        @(negedge clk);
        chk($sformatf("%s_lat2", tag), 32'(res_vld), 32'd0);
        @(negedge clk);
        chk($sformatf("%s_vld", tag), 32'(res_vld), 32'd1);
        chk($sformatf("%s_res", tag), result, er);
        chk($sformatf("%s_st", tag), 32'(state), 32'(es));
    endtask

    logic        bp_sign [5];
    logic [7:0]  bp_exp  [5];
    logic [24:0] bp_mant [5];
    logic [2:0]  bp_grs  [5];
    logic [1:0]  bp_st   [5];
    logic [31:0] bp_res  [5];
    logic [1:0]  bp_ost  [5];

    initial begin
        int          sent;
        int          got;
        int          stalls;
        int          rdy_low;
        int          seen;
        logic        do_acc;
        logic        do_out;
        logic        held_v;
        logic [31:0] held;

        rst      = 1'b1;
        sum_vld  = 1'b0;
        res_rdy  = 1'b1;
        drive(1'b0, 8'd0, 25'd0, 3'd0, 2'b00);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", 32'(res_vld), 32'd0);
        chk("rst_res", result, 32'd0);
        chk("rst_st", 32'(state), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rdy", 32'(sum_rdy), 32'd1);

        // Directed vectors
        run_beat("one_plus_one", 1'b0, 8'd127, 25'h100_0000, 3'b000, 2'b00, 32'h4000_0000, 2'b00);
        run_beat("residue",      1'b0, 8'd127, 25'h000_0001, 3'b000, 2'b00, 32'h3400_0000, 2'b00);
        run_beat("underflow",    1'b0, 8'd10,  25'h000_0001, 3'b000, 2'b00, 32'h0000_0000, 2'b11);
`ifdef FP_NORM_ROUND_EN
        run_beat("round_up",     1'b0, 8'd127, 25'h0FF_FFFF, 3'b100, 2'b00, 32'h4000_0000, 2'b00);
`else
        run_beat("round_trunc",  1'b0, 8'd127, 25'h0FF_FFFF, 3'b100, 2'b00, 32'h3FFF_FFFF, 2'b00);
`endif
        run_beat("tie_even",     1'b0, 8'd127, 25'h080_0000, 3'b100, 2'b00, 32'h3F80_0000, 2'b00);
        run_beat("overflow",     1'b1, 8'd254, 25'h100_0000, 3'b000, 2'b00, 32'hFF80_0000, 2'b10);
        run_beat("nan",          1'b0, 8'd100, 25'h0AB_CDEF, 3'b000, 2'b01, 32'h7FC0_0000, 2'b01);
        run_beat("inf",          1'b0, 8'd50,  25'h012_3456, 3'b000, 2'b10, 32'h7F80_0000, 2'b10);
        run_beat("zero",         1'b1, 8'd90,  25'h000_0000, 3'b000, 2'b00, 32'h0000_0000, 2'b11);
        run_beat("sub_exp0",     1'b0, 8'd0,   25'h080_0000, 3'b000, 2'b00, 32'h0000_0000, 2'b11);

        // Backpressure: five back-to-back beats, res_rdy low in cycles 4..6
        bp_sign[0] = 1'b0; bp_exp[0] = 8'd127; bp_mant[0] = 25'h100_0000; bp_grs[0] = 3'b000; bp_st[0] = 2'b00;
        bp_res[0]  = 32'h4000_0000; bp_ost[0] = 2'b00;
        bp_sign[1] = 1'b0; bp_exp[1] = 8'd127; bp_mant[1] = 25'h000_0001; bp_grs[1] = 3'b000; bp_st[1] = 2'b00;
        bp_res[1]  = 32'h3400_0000; bp_ost[1] = 2'b00;
        bp_sign[2] = 1'b0; bp_exp[2] = 8'd127; bp_mant[2] = 25'h080_0000; bp_grs[2] = 3'b100; bp_st[2] = 2'b00;
        bp_res[2]  = 32'h3F80_0000; bp_ost[2] = 2'b00;
        bp_sign[3] = 1'b1; bp_exp[3] = 8'd254; bp_mant[3] = 25'h100_0000; bp_grs[3] = 3'b000; bp_st[3] = 2'b00;
        bp_res[3]  = 32'hFF80_0000; bp_ost[3] = 2'b10;
        bp_sign[4] = 1'b0; bp_exp[4] = 8'd1;   bp_mant[4] = 25'h000_0000; bp_grs[4] = 3'b000; bp_st[4] = 2'b01;
        bp_res[4]  = 32'h7FC0_0000; bp_ost[4] = 2'b01;

        @(negedge clk);
        sent    = 0;
        got     = 0;
        stalls  = 0;
        rdy_low = 0;
        held_v  = 1'b0;
        held    = 32'd0;
        for (int c = 1; c <= 30 && got < 5; c++) begin
            if (c > 1) @(negedge clk);
            res_rdy = !(c >= 4 && c <= 6);
            if (sent < 5) begin
                drive(bp_sign[sent], bp_exp[sent], bp_mant[sent], bp_grs[sent], bp_st[sent]);
                sum_vld = 1'b1;
            end else begin
                sum_vld = 1'b0;
            end
            #1;
            chk($sformatf("bp_rdy_c%0d", c), 32'(sum_rdy), 32'((c >= 4 && c <= 6) ? 0 : 1));
            if (res_vld && !res_rdy) begin
                stalls++;
                if (held_v) chk($sformatf("bp_hold_c%0d", c), result, held);
                held   = result;
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
            if (!sum_rdy) rdy_low++;
            do_acc = sum_vld && sum_rdy;
            do_out = res_vld && res_rdy;
            @(posedge clk);
            if (do_acc) sent++;
            if (do_out) begin
                chk($sformatf("bp_res%0d", got), result, bp_res[got]);
                chk($sformatf("bp_st%0d", got), 32'(state), 32'(bp_ost[got]));
                got++;
            end
        end
        chk("bp_count", 32'(got), 32'd5);
        chk("bp_stalls", 32'(stalls), 32'd3);
        chk("bp_rdy_low", 32'(rdy_low), 32'd3);
        @(negedge clk);
        sum_vld = 1'b0;
        res_rdy = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (res_vld) seen++;
        end
        chk("bp_no_extra", 32'(seen), 32'd0);

        // Reset with two beats in flight
        @(negedge clk);
        drive(1'b0, 8'd127, 25'h100_0000, 3'b000, 2'b00);
        sum_vld = 1'b1;
        @(negedge clk);
        drive(1'b0, 8'd127, 25'h000_0001, 3'b000, 2'b00);
        @(negedge clk);
        sum_vld = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        chk("mid_rst_vld", 32'(res_vld), 32'd0);
        rst  = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (res_vld) seen++;
        end
        chk("mid_rst_dropped", 32'(seen), 32'd0);
        chk("mid_rst_rdy", 32'(sum_rdy), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
